// File: rtl/nano_pkg.sv
// Shared types for the Nano rover PWM motor driver.
// Build option: NANO_PWM_RAMP_EN enables slew limiting of the applied duty.
package nano_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DEAD  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/nano_pwm_channel.sv
// One H-bridge channel: reversal FSM, applied duty/direction, dead timer and pin registers.
// Build option: NANO_PWM_RAMP_EN selects slew-limited duty (else duty jumps to target).
module nano_pwm_channel
  import nano_pkg::*;
#(
  parameter int DUTY_W       = 8,
  parameter int RAMP_STEP    = 4,
  parameter int DEAD_PERIODS = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_bnd,
  input  logic [DUTY_W-1:0] i_cnt,
  input  logic [DUTY_W-1:0] i_duty_cmd,
  input  logic              i_dir_cmd,
  input  logic              i_run,
  output logic              o_pwm_en,
  output logic              o_in_a,
  output logic              o_in_b,
  output logic              o_at_target
);

  localparam int DEAD_W = (DEAD_PERIODS < 2) ? 1 : $clog2(DEAD_PERIODS + 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_PERIODS);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

`ifdef NANO_PWM_RAMP_EN
  localparam int STEP_C = (RAMP_STEP > (2**DUTY_W - 1)) ? (2**DUTY_W - 1) : RAMP_STEP;
  localparam logic [DUTY_W:0] STEP = (DUTY_W+1)'(STEP_C);

  // Move toward the goal by at most STEP; one extra bit keeps the sum from wrapping.
  function automatic logic [DUTY_W-1:0] step_duty(input logic [DUTY_W-1:0] cur,
                                                 input logic [DUTY_W-1:0] goal);
    logic [DUTY_W:0] c, g, res;
    c = {1'b0, cur};
    g = {1'b0, goal};
    if (g > c)
      res = ((g - c) > STEP) ? (c + STEP) : g;
    else
      res = ((c - g) > STEP) ? (c - STEP) : g;
    return res[DUTY_W-1:0];
  endfunction
`endif

  ch_state_e          r_state, w_state_nxt;
  logic               r_dir_act, w_dir_nxt;
  logic [DEAD_W-1:0]  r_dead, w_dead_nxt;
  logic [DUTY_W-1:0]  r_duty_act, w_duty_nxt;
  logic [DUTY_W-1:0]  w_tgt, w_goal;
  logic               r_pwm_en, r_in_a, r_in_b, r_at_target;

  assign w_tgt = i_run ? i_duty_cmd : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir_act;
    w_dead_nxt  = r_dead;
    w_duty_nxt  = r_duty_act;
    w_goal      = '0;
    if (i_bnd) begin
      case (r_state)
        ST_RUN: begin
          if (i_dir_cmd != r_dir_act) begin
            if (r_duty_act != '0) begin
              w_state_nxt = ST_DRAIN;
            end else begin
              w_state_nxt = ST_DEAD;
              w_dead_nxt  = DEAD_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (i_dir_cmd == r_dir_act) begin
            w_state_nxt = ST_RUN;
          end else if (r_duty_act == '0) begin
            w_state_nxt = ST_DEAD;
            w_dead_nxt  = DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          // Direction is taken from the command seen on the final dead boundary.
          if (r_dead <= DEAD_ONE) begin
            w_state_nxt = ST_RUN;
            w_dir_nxt   = i_dir_cmd;
          end else begin
            w_dead_nxt = r_dead - DEAD_ONE;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
      w_goal = (w_state_nxt == ST_RUN) ? w_tgt : '0;
`ifdef NANO_PWM_RAMP_EN
      w_duty_nxt = step_duty(r_duty_act, w_goal);
`else
      w_duty_nxt = w_goal;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_dir_act   <= 1'b1;
      r_dead      <= '0;
      r_duty_act  <= '0;
      r_pwm_en    <= 1'b0;
      r_in_a      <= 1'b1;
      r_in_b      <= 1'b0;
      r_at_target <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_dir_act   <= w_dir_nxt;
      r_dead      <= w_dead_nxt;
      r_duty_act  <= w_duty_nxt;
      // Pins are gated by state so both bridge legs can never be driven high together.
      r_pwm_en    <= (i_cnt < r_duty_act) && (r_state != ST_DEAD);
      r_in_a      <= (r_state != ST_DEAD) && r_dir_act;
      r_in_b      <= (r_state != ST_DEAD) && !r_dir_act;
      r_at_target <= (r_state == ST_RUN) && (r_duty_act == w_tgt);
    end
  end

  assign o_pwm_en    = r_pwm_en;
  assign o_in_a      = r_in_a;
  assign o_in_b      = r_in_b;
  assign o_at_target = r_at_target;

endmodule

// File: rtl/nano_pwm_drive.sv
// N-channel PWM H-bridge driver: shared prescaler/period counter plus per-channel reversal logic.
// Build option: NANO_PWM_RAMP_EN enables per-boundary slew limiting in every channel.
module nano_pwm_drive
  import nano_pkg::*;
#(
  parameter int CH           = 2,
  parameter int DUTY_W       = 8,
  parameter int PRESC_DIV    = 1,
  parameter int RAMP_STEP    = 4,
  parameter int DEAD_PERIODS = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic [CH*DUTY_W-1:0] duty_cmd,
  input  logic [CH-1:0]        dir_cmd,
  output logic [CH-1:0]        pwm_en,
  output logic [CH-1:0]        in_a,
  output logic [CH-1:0]        in_b,
  output logic [CH-1:0]        at_target,
  output logic                 period_strobe
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST   = DUTY_W'(2**DUTY_W - 2);

  logic [PW-1:0]        r_presc;
  logic [DUTY_W-1:0]    r_cnt;
  logic                 r_strobe;
  logic                 r_run;
  logic [CH*DUTY_W-1:0] r_duty_cmd;
  logic [CH-1:0]        r_dir_cmd;
  logic                 w_tick, w_bnd;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_bnd  = w_tick && (r_cnt == CNT_LAST);

  // The period is 2^DUTY_W-1 ticks so an all-ones duty holds the enable high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc  <= '0;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_presc  <= w_tick ? '0 : r_presc + PW'(1);
      if (w_bnd)
        r_cnt <= '0;
      else if (w_tick)
        r_cnt <= r_cnt + DUTY_W'(1);
      r_strobe <= w_bnd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run      <= 1'b0;
      r_duty_cmd <= '0;
      r_dir_cmd  <= '1;
    end else begin
      r_run      <= run;
      r_duty_cmd <= duty_cmd;
      r_dir_cmd  <= dir_cmd;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    nano_pwm_channel #(
      .DUTY_W      (DUTY_W),
      .RAMP_STEP   (RAMP_STEP),
      .DEAD_PERIODS(DEAD_PERIODS)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .i_bnd      (w_bnd),
      .i_cnt      (r_cnt),
      .i_duty_cmd (r_duty_cmd[g*DUTY_W +: DUTY_W]),
      .i_dir_cmd  (r_dir_cmd[g]),
      .i_run      (r_run),
      .o_pwm_en   (pwm_en[g]),
      .o_in_a     (in_a[g]),
      .o_in_b     (in_b[g]),
      .o_at_target(at_target[g])
    );
  end

  assign period_strobe = r_strobe;

endmodule

// File: tb/tb_nano_pwm_drive.sv
// Directed bench for nano_pwm_drive (CH=2, DUTY_W=4, PRESC_DIV=1, RAMP_STEP=4, DEAD_PERIODS=2).
// Expectations follow NANO_PWM_RAMP_EN when it is defined for the build.
module tb_nano_pwm_drive;

`ifdef NANO_PWM_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] duty_cmd;
  logic [1:0] dir_cmd;
  logic [1:0] pwm_en, in_a, in_b, at_target;
  logic       period_strobe;

  int n_tests = 0;
  int n_fail  = 0;

  nano_pwm_drive #(
    .CH(2), .DUTY_W(4), .PRESC_DIV(1), .RAMP_STEP(4), .DEAD_PERIODS(2)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .duty_cmd(duty_cmd), .dir_cmd(dir_cmd),
    .pwm_en(pwm_en), .in_a(in_a), .in_b(in_b), .at_target(at_target),
    .period_strobe(period_strobe)
  );

  always #5 clock = ~clock;

  // Observes one full PWM period starting from a strobe negedge; ends on the next strobe negedge.
  task automatic measure(output int hi0, output int hi1, output logic [1:0] a,
                         output logic [1:0] b, output logic [1:0] at,
                         output int nstb, output logic last_stb);
    hi0 = 0; hi1 = 0; nstb = 0; a = '0; b = '0; at = '0; last_stb = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clock);
      hi0  += int'(pwm_en[0]);
      hi1  += int'(pwm_en[1]);
      nstb += int'(period_strobe);
      if (j == 2) begin a = in_a; b = in_b; at = at_target; end
      if (j == 14) last_stb = period_strobe;
    end
  endtask

  task automatic test_reset();
    int hi0, hi1, nstb; logic [1:0] a, b, at; logic ls; bit found;
    reset = 1'b1; run = 1'b0; duty_cmd = 8'h00; dir_cmd = 2'b11;
    repeat (2) @(negedge clock);
    n_tests++; if (pwm_en !== 2'b00) begin n_fail++; $display("FAIL rst_pwm_en got %b want 00", pwm_en); end
    n_tests++; if (in_a !== 2'b11) begin n_fail++; $display("FAIL rst_in_a got %b want 11", in_a); end
    n_tests++; if (in_b !== 2'b00) begin n_fail++; $display("FAIL rst_in_b got %b want 00", in_b); end
    n_tests++; if (at_target !== 2'b11) begin n_fail++; $display("FAIL rst_at_target got %b want 11", at_target); end
    n_tests++; if (period_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe got %b want 0", period_strobe); end
    reset = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (period_strobe === 1'b1) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL first_strobe got none want within 40 clocks"); end
    measure(hi0, hi1, a, b, at, nstb, ls);
    n_tests++; if (nstb != 1 || ls !== 1'b1) begin n_fail++; $display("FAIL strobe_period got count=%0d last=%b want 1/1", nstb, ls); end
    n_tests++; if (hi0 != 0 || hi1 != 0) begin n_fail++; $display("FAIL run0_pwm got %0d/%0d want 0/0", hi0, hi1); end
    n_tests++; if (a !== 2'b11 || b !== 2'b00) begin n_fail++; $display("FAIL run0_pins got a=%b b=%b want 11/00", a, b); end
  endtask

  task automatic test_ramp();
    int hi0, hi1, nstb; logic [1:0] a, b, at; logic ls;
    run = 1'b1; duty_cmd = {4'd5, 4'd8};
    measure(hi0, hi1, a, b, at, nstb, ls);
    n_tests++; if (hi0 != 0) begin n_fail++; $display("FAIL ramp_pre got %0d want 0", hi0); end
    measure(hi0, hi1, a, b, at, nstb, ls);
    n_tests++; if (hi0 != (RAMP ? 4 : 8)) begin n_fail++; $display("FAIL ramp_p1_ch0 got %0d want %0d", hi0, RAMP ? 4 : 8); end
    n_tests++; if (hi1 != (RAMP ? 4 : 5)) begin n_fail++; $display("FAIL ramp_p1_ch1 got %0d want %0d", hi1, RAMP ? 4 : 5); end
    n_tests++; if (at !== (RAMP ? 2'b00 : 2'b11)) begin n_fail++; $display("FAIL ramp_p1_at got %b want %b", at, RAMP ? 2'b00 : 2'b11); end
    measure(hi0, hi1, a, b, at, nstb, ls);
    n_tests++; if (hi0 != 8 || hi1 != 5) begin n_fail++; $display("FAIL ramp_p2 got %0d/%0d want 8/5", hi0, hi1); end
    n_tests++; if (at !== 2'b11) begin n_fail++; $display("FAIL ramp_p2_at got %b want 11", at); end
    n_tests++; if (a !== 2'b11 || b !== 2'b00) begin n_fail++; $display("FAIL ramp_pins got a=%b b=%b want 11/00", a, b); end
  endtask

  task automatic test_back_to_back();
    int hi0, hi1, nstb; logic [1:0] a, b, at; logic ls;
    hi0 = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clock);
      hi0 += int'(pwm_en[0]);
      if (j == 3)  duty_cmd[3:0] = 4'd2;
      if (j == 8)  duty_cmd[3:0] = 4'd15;
      if (j == 12) duty_cmd[3:0] = 4'd8;
    end
    n_tests++; if (hi0 != 8) begin n_fail++; $display("FAIL midperiod_cmd got %0d want 8", hi0); end
    measure(hi0, hi1, a, b, at, nstb, ls);
    n_tests++; if (hi0 != 8 || at[0] !== 1'b1) begin n_fail++; $display("FAIL after_glitch_cmd got %0d at=%b want 8 at=1", hi0, at[0]); end
  endtask

  task automatic test_reverse();
    int hi0, hi1, nstb; logic [1:0] a, b, at; logic ls;
    int exp_hi [6]; bit exp_a [6]; bit exp_b [6];
    if (RAMP) begin
      exp_hi = '{4, 0, 0, 0, 4, 8}; exp_a = '{1, 1, 0, 0, 0, 0}; exp_b = '{0, 0, 0, 0, 1, 1};
    end else begin
      exp_hi = '{0, 0, 0, 8, 8, 8}; exp_a = '{1, 0, 0, 0, 0, 0}; exp_b = '{0, 0, 0, 1, 1, 1};
    end
    dir_cmd = 2'b10;
    measure(hi0, hi1, a, b, at, nstb, ls);
    n_tests++; if (hi0 != 8 || a[0] !== 1'b1) begin n_fail++; $display("FAIL rev_pre got %0d a=%b want 8 a=1", hi0, a[0]); end
    for (int p = 0; p < 6; p++) begin
      measure(hi0, hi1, a, b, at, nstb, ls);
      n_tests++; if (hi0 != exp_hi[p] || a[0] !== exp_a[p] || b[0] !== exp_b[p]) begin
        n_fail++; $display("FAIL rev_p%0d got duty=%0d a=%b b=%b want %0d/%b/%b", p, hi0, a[0], b[0], exp_hi[p], exp_a[p], exp_b[p]);
      end
      n_tests++; if (hi1 != 5 || a[1] !== 1'b1 || b[1] !== 1'b0) begin
        n_fail++; $display("FAIL rev_ch1_p%0d got duty=%0d a=%b b=%b want 5/1/0", p, hi1, a[1], b[1]);
      end
      if (p == 2) begin
        n_tests++; if (at[0] !== 1'b0) begin n_fail++; $display("FAIL dead_at_target got %b want 0", at[0]); end
      end
    end
  endtask

  task automatic test_revert();
    int hi0, hi1, nstb; logic [1:0] a, b, at; logic ls;
    dir_cmd = 2'b11;
    measure(hi0, hi1, a, b, at, nstb, ls);
    dir_cmd = 2'b10;
    measure(hi0, hi1, a, b, at, nstb, ls);
    n_tests++; if (hi0 != (RAMP ? 4 : 0) || a[0] !== 1'b0 || b[0] !== 1'b1) begin
      n_fail++; $display("FAIL revert_drain got duty=%0d a=%b b=%b want %0d/0/1", hi0, a[0], b[0], RAMP ? 4 : 0);
    end
    for (int p = 0; p < 2; p++) begin
      measure(hi0, hi1, a, b, at, nstb, ls);
      n_tests++; if (hi0 != 8 || a[0] !== 1'b0 || b[0] !== 1'b1 || at[0] !== 1'b1) begin
        n_fail++; $display("FAIL revert_run%0d got duty=%0d a=%b b=%b at=%b want 8/0/1/1", p, hi0, a[0], b[0], at[0]);
      end
    end
  endtask

  task automatic test_full_zero();
    int hi0, hi1, nstb; logic [1:0] a, b, at; logic ls;
    duty_cmd[3:0] = 4'd15;
    measure(hi0, hi1, a, b, at, nstb, ls);
    measure(hi0, hi1, a, b, at, nstb, ls);
    n_tests++; if (hi0 != (RAMP ? 12 : 15)) begin n_fail++; $display("FAIL full_p1 got %0d want %0d", hi0, RAMP ? 12 : 15); end
    measure(hi0, hi1, a, b, at, nstb, ls);
    n_tests++; if (hi0 != 15) begin n_fail++; $display("FAIL full_const_high got %0d want 15", hi0); end
    duty_cmd[3:0] = 4'd0;
    measure(hi0, hi1, a, b, at, nstb, ls);
    measure(hi0, hi1, a, b, at, nstb, ls);
    n_tests++; if (hi0 != (RAMP ? 11 : 0)) begin n_fail++; $display("FAIL zero_p1 got %0d want %0d", hi0, RAMP ? 11 : 0); end
    repeat (2) measure(hi0, hi1, a, b, at, nstb, ls);
    for (int p = 0; p < 2; p++) begin
      measure(hi0, hi1, a, b, at, nstb, ls);
      n_tests++; if (hi0 != 0) begin n_fail++; $display("FAIL zero_const_low%0d got %0d want 0", p, hi0); end
    end
  endtask

  task automatic test_reset_mid_dead();
    bit found;
    dir_cmd = 2'b11;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clock);
      if (in_a[0] === 1'b0 && in_b[0] === 1'b0) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL enter_dead got none want dead pins within 60 clocks"); end
    reset = 1'b1;
    #1;
    n_tests++; if (pwm_en !== 2'b00 || in_a !== 2'b11 || in_b !== 2'b00) begin
      n_fail++; $display("FAIL async_rst_pins got en=%b a=%b b=%b want 00/11/00", pwm_en, in_a, in_b);
    end
    n_tests++; if (at_target !== 2'b11 || period_strobe !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_status got at=%b stb=%b want 11/0", at_target, period_strobe);
    end
    run = 1'b0; duty_cmd = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_back_to_back();
    test_reverse();
    test_revert();
    test_full_zero();
    test_reset_mid_dead();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
